// File: rtl/segre_pkg.sv
// segre_pkg: shared types and defaults for the multi-channel memory arbiter.
package segre_pkg;

    localparam int unsigned ARB_NUM_CH     = 2;
    localparam int unsigned ARB_FIFO_DEPTH = 4;
    localparam int unsigned ARB_ADDR_W     = 32;
    localparam int unsigned ARB_LINE_BITS  = 128;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RSP
    } arb_state_e;

    typedef struct packed {
        logic                     wr;
        logic [ARB_ADDR_W-1:0]    addr;
        logic [ARB_LINE_BITS-1:0] line;
    } arb_entry_t;

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// segre_mem_arbiter_if: requester-side and memory-side bus of the arbiter.
// slave = arbiter view, master = environment (caches + memory) view.
interface segre_mem_arbiter_if import segre_pkg::*; #(
    parameter int unsigned NUM_CH    = ARB_NUM_CH,
    parameter int unsigned ADDR_W    = ARB_ADDR_W,
    parameter int unsigned LINE_BITS = ARB_LINE_BITS
);
    logic [NUM_CH-1:0]           req_valid_i;
    logic [NUM_CH-1:0]           req_ready_o;
    logic [NUM_CH-1:0]           req_wr_i;
    logic [NUM_CH*ADDR_W-1:0]    req_addr_i;
    logic [NUM_CH*LINE_BITS-1:0] req_line_i;
    logic [NUM_CH-1:0]           rsp_valid_o;
    logic [LINE_BITS-1:0]        rsp_line_o;
    logic                        mem_req_valid_o;
    logic                        mem_req_ready_i;
    logic                        mem_rd_o;
    logic                        mem_wr_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [LINE_BITS-1:0]        mem_line_o;
    logic                        mem_rsp_valid_i;
    logic [LINE_BITS-1:0]        mem_rsp_line_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i, req_line_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_line_i,
        output req_ready_o, rsp_valid_o, rsp_line_o,
        output mem_req_valid_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_line_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_addr_i, req_line_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_line_i,
        input  req_ready_o, rsp_valid_o, rsp_line_o,
        input  mem_req_valid_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_line_o
    );
endinterface

// File: rtl/segre_arb_fifo.sv
// segre_arb_fifo: per-channel request FIFO. Pointers carry one extra wrap
// bit so full/empty are distinguished without a counter.
module segre_arb_fifo import segre_pkg::*; #(
    parameter int unsigned DEPTH   = ARB_FIFO_DEPTH,
    parameter type         entry_t = arb_entry_t
) (
    input  logic   clk_i,
    input  logic   rsn_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t data_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;
    entry_t           mem_q [DEPTH];

    // Status flags, guarded push/pop and next pointers
    always_comb begin
        full_o   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        data_o   = mem_q[rd_ptr_q[IDX_W-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage (contents are don't-care while empty, so no reset)
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: round-robin arbiter of NUM_CH request FIFOs onto one
// memory port, one transaction outstanding, response routed to the issuer.
// Optional macro SEGRE_ARB_STATS_EN adds grant and full-stall counters.
module segre_mem_arbiter import segre_pkg::*; #(
    parameter int unsigned NUM_CH     = ARB_NUM_CH,
    parameter int unsigned FIFO_DEPTH = ARB_FIFO_DEPTH,
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned LINE_BITS  = ARB_LINE_BITS
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,
    segre_mem_arbiter_if.slave      bus,
    output logic                    busy_o
`ifdef SEGRE_ARB_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]    grant_cnt_o,
    output logic [31:0]             full_stall_cnt_o
`endif
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef struct packed {
        logic                 wr;
        logic [ADDR_W-1:0]    addr;
        logic [LINE_BITS-1:0] line;
    } entry_t;

    entry_t [NUM_CH-1:0] fifo_din;
    entry_t [NUM_CH-1:0] fifo_head;
    logic   [NUM_CH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;

    arb_state_e           state_q, state_d;
    logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]      grant_id_q, grant_id_d;
    entry_t               issue_q, issue_d;
    logic [NUM_CH-1:0]    rsp_valid_q, rsp_valid_d;
    logic [LINE_BITS-1:0] rsp_line_q, rsp_line_d;
    logic                 grant_found;
    logic [CH_W-1:0]      grant_pick;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign fifo_din[k] = {bus.req_wr_i[k],
                              bus.req_addr_i[k*ADDR_W +: ADDR_W],
                              bus.req_line_i[k*LINE_BITS +: LINE_BITS]};

        segre_arb_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rsn_i   (rsn_i),
            .push_i  (fifo_push[k]),
            .pop_i   (fifo_pop[k]),
            .data_i  (fifo_din[k]),
            .data_o  (fifo_head[k]),
            .full_o  (fifo_full[k]),
            .empty_o (fifo_empty[k])
        );
    end

    // Ready comes from registered full only, so a same-cycle pop never opens it
    assign bus.req_ready_o = ~fifo_full;
    assign fifo_push       = bus.req_valid_i & ~fifo_full;

    // First non-empty channel searching upward from rr_ptr, wrapping
    always_comb begin : grant_search
        logic [CH_W-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_pick  = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
            if (!grant_found && !fifo_empty[cand]) begin
                grant_found = 1'b1;
                grant_pick  = cand;
            end
        end
    end

    // Next-state: grant/pop in IDLE, hold request in ISSUE, route response
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        issue_d     = issue_q;
        rsp_valid_d = '0;
        rsp_line_d  = rsp_line_q;
        fifo_pop    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_found) begin
                    fifo_pop[grant_pick] = 1'b1;
                    issue_d              = fifo_head[grant_pick];
                    grant_id_d           = grant_pick;
                    rr_ptr_d             = (grant_pick == CH_W'(NUM_CH - 1)) ? '0 : grant_pick + 1'b1;
                    state_d              = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_req_ready_i) begin
                    state_d = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if (bus.mem_rsp_valid_i) begin
                    rsp_valid_d[grant_id_q] = 1'b1;
                    rsp_line_d              = bus.mem_rsp_line_i;
                    state_d                 = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            issue_q     <= '0;
            rsp_valid_q <= '0;
            rsp_line_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            issue_q     <= issue_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_line_q  <= rsp_line_d;
        end
    end

    assign bus.mem_req_valid_o = (state_q == ARB_ISSUE);
    assign bus.mem_rd_o        = (state_q == ARB_ISSUE) && !issue_q.wr;
    assign bus.mem_wr_o        = (state_q == ARB_ISSUE) && issue_q.wr;
    assign bus.mem_addr_o      = issue_q.addr;
    assign bus.mem_line_o      = issue_q.line;
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_line_o      = rsp_line_q;
    assign busy_o              = (state_q != ARB_IDLE) || !(&fifo_empty);

`ifdef SEGRE_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_CH];
    logic [31:0] grant_cnt_d [NUM_CH];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: grants per channel on handshake, cycles with a refused push
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            grant_cnt_d[k] = grant_cnt_q[k];
            if ((state_q == ARB_ISSUE) && bus.mem_req_ready_i &&
                (grant_id_q == CH_W'(k)) && !(&grant_cnt_q[k])) begin
                grant_cnt_d[k] = grant_cnt_q[k] + 32'd1;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if ((|(bus.req_valid_i & fifo_full)) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                grant_cnt_q[k] <= grant_cnt_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt_out
        assign grant_cnt_o[k*32 +: 32] = grant_cnt_q[k];
    end
    assign full_stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_segre_mem_arbiter;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 128;

    logic clk = 1'b0;
    logic rsn;
    logic busy;
    always #5 clk = ~clk;

    segre_mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_BITS(LW)) bus ();

`ifdef SEGRE_ARB_STATS_EN
    logic [NCH*32-1:0] grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    segre_mem_arbiter #(
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .LINE_BITS  (LW)
    ) dut (
        .clk_i  (clk),
        .rsn_i  (rsn),
        .bus    (bus),
        .busy_o (busy)
`ifdef SEGRE_ARB_STATS_EN
        ,
        .grant_cnt_o      (grant_cnt),
        .full_stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } req_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    req_t        q [NCH][$];
    int unsigned rr;
    bit          txn, issued;
    int unsigned g_ch;
    req_t        g_req;
    logic [NCH-1:0] exp_rsp;
    bit          exp_rsp_rd;
    logic [LW-1:0] exp_line;
    int unsigned m_grant [NCH];
    logic [31:0] m_stall;
    int unsigned log_ch [$];
    logic [AW-1:0] log_addr [$];
    bit          chk_en;

    // Drive values
    logic           drv_rsn;
    logic [NCH-1:0] drv_valid, drv_wr;
    logic [AW-1:0]  drv_addr [NCH];
    logic [LW-1:0]  drv_line [NCH];
    logic           drv_mready, drv_mrsp;
    logic [LW-1:0]  drv_mrsp_line;
    bit             auto_mem;
    int unsigned    ready_pct;
    int unsigned    rsp_wait;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int qtotal();
        int s = 0;
        for (int k = 0; k < NCH; k++) s += q[k].size();
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            q[k].delete();
            m_grant[k] = 0;
        end
        rr = 0; txn = 0; issued = 0; g_ch = 0;
        exp_rsp = '0; exp_rsp_rd = 0; m_stall = '0;
    endtask

    task automatic check_outputs();
        logic [NCH-1:0] exp_ready;
        for (int k = 0; k < NCH; k++) exp_ready[k] = (q[k].size() < DEPTH);
        check_eq("req_ready", bus.req_ready_o, exp_ready);
        check_eq("rsp_valid", bus.rsp_valid_o, exp_rsp);
        if (exp_rsp != '0 && exp_rsp_rd) check_eq("rsp_line", bus.rsp_line_o, exp_line);
        check_eq("mem_req_valid", bus.mem_req_valid_o, txn && !issued);
        if (txn && !issued) begin
            check_eq("mem_addr", bus.mem_addr_o, g_req.addr);
            check_eq("mem_rd", bus.mem_rd_o, !g_req.wr);
            check_eq("mem_wr", bus.mem_wr_o, g_req.wr);
            if (g_req.wr) check_eq("mem_line", bus.mem_line_o, g_req.line);
        end else begin
            check_eq("mem_rdwr_idle", {bus.mem_rd_o, bus.mem_wr_o}, 2'b00);
        end
        check_eq("busy", busy, txn || (qtotal() > 0));
`ifdef SEGRE_ARB_STATS_EN
        for (int k = 0; k < NCH; k++) check_eq("grant_cnt", grant_cnt[k*32 +: 32], m_grant[k]);
        check_eq("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    // Advance the model across the upcoming rising edge
    task automatic predict();
        bit [NCH-1:0] acc;
        bit stall;
        logic [NCH-1:0] nrsp;
        if (!drv_rsn) begin
            model_reset();
            return;
        end
        stall = 0;
        for (int k = 0; k < NCH; k++) begin
            acc[k] = drv_valid[k] && (q[k].size() < DEPTH);
            if (drv_valid[k] && !acc[k]) stall = 1;
        end
        if (stall && m_stall != '1) m_stall++;
        nrsp = '0;
        if (txn && issued) begin
            if (drv_mrsp) begin
                nrsp[g_ch] = 1'b1;
                exp_line   = drv_mrsp_line;
                exp_rsp_rd = !g_req.wr;
                txn        = 0;
            end
        end else if (txn) begin
            if (drv_mready) begin
                issued = 1;
                m_grant[g_ch]++;
                rsp_wait = $urandom_range(0, 3);
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                int unsigned c;
                c = (rr + i) % NCH;
                if (!txn && q[c].size() > 0) begin
                    g_ch   = c;
                    g_req  = q[c].pop_front();
                    txn    = 1;
                    issued = 0;
                    rr     = (c + 1) % NCH;
                    log_ch.push_back(c);
                    log_addr.push_back(g_req.addr);
                end
            end
        end
        exp_rsp = nrsp;
        for (int k = 0; k < NCH; k++) begin
            if (acc[k]) q[k].push_back({drv_wr[k], drv_addr[k], drv_line[k]});
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) check_outputs();
        if (auto_mem) begin
            drv_mready    = ($urandom_range(0, 99) < ready_pct);
            drv_mrsp_line = rand_line();
            if (txn && issued) begin
                if (rsp_wait == 0) drv_mrsp = 1'b1;
                else begin
                    drv_mrsp = 1'b0;
                    rsp_wait--;
                end
            end else begin
                drv_mrsp = ($urandom_range(0, 9) == 0);
            end
        end
        rsn                 = drv_rsn;
        bus.req_valid_i     = drv_valid;
        bus.req_wr_i        = drv_wr;
        for (int k = 0; k < NCH; k++) begin
            bus.req_addr_i[k*AW +: AW] = drv_addr[k];
            bus.req_line_i[k*LW +: LW] = drv_line[k];
        end
        bus.mem_req_ready_i = drv_mready;
        bus.mem_rsp_valid_i = drv_mrsp;
        bus.mem_rsp_line_i  = drv_mrsp_line;
        predict();
    endtask

    task automatic quiet();
        drv_valid = '0; drv_wr = '0; drv_mready = 1'b0; drv_mrsp = 1'b0;
    endtask

    task automatic do_reset();
        drv_rsn = 1'b0;
        step();
        drv_rsn = 1'b1;
        step();
    endtask

    task automatic drain(input string tag);
        drv_valid = '0;
        auto_mem  = 1;
        ready_pct = 100;
        for (int n = 0; n < 300 && (txn || qtotal() > 0); n++) step();
        step();
        step();
        check_eq(tag, txn || (qtotal() > 0), 1'b0);
        auto_mem = 0;
        quiet();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_cnt, rej_cnt;
        int unsigned exp_rr [6];
        int unsigned ch1_idx;
        rsn = 1'b0;
        bus.req_valid_i = '0; bus.req_wr_i = '0; bus.req_addr_i = '0; bus.req_line_i = '0;
        bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_line_i = '0;
        for (int k = 0; k < NCH; k++) begin
            drv_addr[k] = '0;
            drv_line[k] = '0;
        end
        drv_mrsp_line = '0;
        auto_mem = 0; ready_pct = 100; rsp_wait = 0; chk_en = 0;
        quiet();
        model_reset();

        // Reset state
        drv_rsn = 1'b0;
        step();
        chk_en = 1;
        drv_rsn = 1'b1;
        step();
        check_eq("rst_mem_addr", bus.mem_addr_o, '0);
        check_eq("rst_mem_line", bus.mem_line_o, '0);
        check_eq("rst_rsp_line", bus.rsp_line_o, '0);
        check_eq("rst_ready", bus.req_ready_o, 2'b11);
        check_eq("rst_busy", busy, 1'b0);

        // Single read on ch0 with 2-cycle issue latency
        drv_valid = 2'b01; drv_wr = 2'b00; drv_addr[0] = 32'h0000_1000;
        step();
        drv_valid = '0;
        step();
        check_eq("single_early", bus.mem_req_valid_o, 1'b0);
        step();
        check_eq("single_valid", bus.mem_req_valid_o, 1'b1);
        check_eq("single_addr", bus.mem_addr_o, 32'h0000_1000);
        drv_mready = 1'b1;
        step();
        drv_mready = 1'b0;
        drv_mrsp = 1'b1;
        drv_mrsp_line = {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF};
        step();
        drv_mrsp = 1'b0;
        step();
        check_eq("single_rsp", bus.rsp_valid_o, 2'b01);
        check_eq("single_line", bus.rsp_line_o, {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF});
        step();

        // Write ack on ch1, then a spurious response in IDLE
        drv_valid = 2'b10; drv_wr = 2'b10; drv_addr[1] = 32'h0000_2000; drv_line[1] = {16{8'hA5}};
        step();
        quiet();
        step();
        step();
        check_eq("wr_mem_wr", bus.mem_wr_o, 1'b1);
        check_eq("wr_mem_line", bus.mem_line_o, {16{8'hA5}});
        drv_mready = 1'b1;
        step();
        drv_mready = 1'b0;
        drv_mrsp = 1'b1;
        step();
        drv_mrsp = 1'b0;
        step();
        check_eq("wr_rsp", bus.rsp_valid_o, 2'b10);
        drv_mrsp = 1'b1;
        step();
        drv_mrsp = 1'b0;
        step();
        check_eq("spurious_rsp", bus.rsp_valid_o, 2'b00);
        step();

        // Round-robin from a fresh reset: both channels push 3 together
        do_reset();
        log_ch.delete(); log_addr.delete();
        for (int i = 0; i < 3; i++) begin
            drv_valid = 2'b11; drv_wr = 2'b00;
            drv_addr[0] = 32'h0000_5000 + 32'(i * 16);
            drv_addr[1] = 32'h0000_6000 + 32'(i * 16);
            step();
        end
        drain("rr_drain");
        exp_rr = '{0, 1, 0, 1, 0, 1};
        check_eq("rr_count", log_ch.size(), 6);
        for (int i = 0; i < 6 && i < log_ch.size(); i++) check_eq("rr_order", log_ch[i], exp_rr[i]);

        // Full FIFO: ch0 request parked in ISSUE, ch1 pushes 6 with backpressure
        do_reset();
        log_ch.delete(); log_addr.delete();
        drv_valid = 2'b01; drv_wr = '0; drv_addr[0] = 32'h0000_4000;
        step();
        quiet();
        step();
        step();
        acc_cnt = 0; rej_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drv_valid = 2'b10; drv_wr = '0; drv_addr[1] = 32'h0000_3000 + 32'(i * 16);
            drv_line[1] = rand_line();
            step();
            if (bus.req_ready_o[1]) acc_cnt++;
            else rej_cnt++;
        end
        drv_valid = '0;
        for (int i = 0; i < 5; i++) step();
        check_eq("full_accepted", acc_cnt, 4);
        check_eq("full_rejected", rej_cnt, 2);
        check_eq("full_hold_addr", bus.mem_addr_o, 32'h0000_4000);
        drain("full_drain");
        ch1_idx = 0;
        for (int i = 0; i < log_ch.size(); i++) begin
            if (log_ch[i] == 1) begin
                check_eq("full_order", log_addr[i], 32'h0000_3000 + 32'(ch1_idx * 16));
                ch1_idx++;
            end
        end
        check_eq("full_issued", ch1_idx, 4);

        // Reset while waiting for a response
        drv_valid = 2'b01; drv_wr = '0; drv_addr[0] = 32'h0000_7000;
        step();
        quiet();
        step();
        step();
        drv_mready = 1'b1;
        step();
        drv_mready = 1'b0;
        drv_rsn = 1'b0;
        step();
        drv_rsn = 1'b1;
        drv_mrsp = 1'b1;
        step();
        drv_mrsp = 1'b0;
        step();
        check_eq("rst_wait_rsp", bus.rsp_valid_o, 2'b00);
        check_eq("rst_wait_ready", bus.req_ready_o, 2'b11);
        check_eq("rst_wait_busy", busy, 1'b0);
        step();

        // Random traffic
        auto_mem = 1;
        for (int blk = 0; blk < 6; blk++) begin
            int unsigned push_pct;
            ready_pct = $urandom_range(20, 100);
            push_pct  = $urandom_range(10, 90);
            for (int c = 0; c < 250; c++) begin
                for (int k = 0; k < NCH; k++) begin
                    drv_valid[k] = ($urandom_range(0, 99) < push_pct);
                    drv_wr[k]    = $urandom_range(0, 1);
                    drv_addr[k]  = $urandom;
                    drv_line[k]  = rand_line();
                end
                step();
            end
        end
        drain("rand_drain");
        check_eq("final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Parametrised successor of the fixed two-source ICACHE/DCACHE arbiter buffer; arbitrates cache line-fill and writeback requests from NUM_CH requesters onto one memory port.
- One per-channel request FIFO, round-robin grant, one outstanding memory transaction; the response is routed back to the issuing channel.
- Sits between the cache miss logic (ICACHE = channel 0, DCACHE = channel 1 by default) and main memory.

Parameters:
- NUM_CH, 2, number of requesting channels (≥2).
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2).
- ADDR_W, 32, request address width.
- LINE_BITS, 128, cache line width in bits.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  synchronous active-low reset
- req_valid_i  in  NUM_CH  per-channel request valid
- req_ready_o  out  NUM_CH  per-channel FIFO not full
- req_wr_i  in  NUM_CH  1 = write (writeback), 0 = read (fill)
- req_addr_i  in  NUM_CH*ADDR_W  per-channel address, channel k at [k*ADDR_W +: ADDR_W]
- req_line_i  in  NUM_CH*LINE_BITS  write data, same packing
- rsp_valid_o  out  NUM_CH  one-cycle completion pulse to the issuing channel
- rsp_line_o  out  LINE_BITS  read data, shared by all channels, qualified by rsp_valid_o
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_rd_o, mem_wr_o  out  1 each  memory operation
- mem_addr_o  out  ADDR_W  memory address
- mem_line_o  out  LINE_BITS  memory write data
- mem_rsp_valid_i  in  1  memory completion (read data or write ack)
- mem_rsp_line_i  in  LINE_BITS  memory read data
- busy_o  out  1  FSM not IDLE or any FIFO non-empty

Behaviour:
- Reset (rsn_i low at a rising clock edge): all FIFOs empty, FSM IDLE, rr_ptr = 0. Outputs: req_ready_o all 1s, rsp_valid_o 0, mem_req_valid_o/rd/wr 0, mem_addr_o/mem_line_o/rsp_line_o 0, busy_o 0.
- Push: channel k enqueues {wr, addr, line} when req_valid_i[k] && req_ready_o[k]. req_ready_o[k] = !full[k] from registered state only; a pop in the same cycle does not open a full FIFO (no fall-through).
- FSM IDLE: if any FIFO is non-empty, grant the first non-empty channel searching from rr_ptr upward modulo NUM_CH. Pop its head into the issue register, latch grant_id, set rr_ptr = (grant_id+1) mod NUM_CH, go to ISSUE. Minimum latency from push to mem_req_valid_o is 2 cycles.
- FSM ISSUE: mem_req_valid_o = 1 with stable rd/wr/addr/line until mem_req_ready_i; on handshake go to WAIT_RSP. mem_rd_o = !wr and mem_wr_o = wr; never both set.
- FSM WAIT_RSP: on mem_rsp_valid_i, pulse rsp_valid_o[grant_id] for exactly one cycle, the next cycle, with rsp_line_o = registered mem_rsp_line_i; go to IDLE. Write responses also pulse rsp_valid_o; rsp_line_o is then don't-care.
- Ignore mem_rsp_valid_i in IDLE and ISSUE (no state change).
- Only one transaction outstanding. Per-channel order is preserved; cross-channel order follows round-robin.
- A channel pushing into its own FIFO while it is granted is legal.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wrapping modulo 2*FIFO_DEPTH. full = MSBs differ and LSBs are equal.
- Reset mid-transaction: queued and in-flight requests are dropped, and no rsp_valid_o pulse is emitted for them.

Optional Feature:
- SEGRE_ARB_STATS_EN
  - Defined: adds output grant_cnt_o (NUM_CH*32), one saturating 32-bit counter per channel, incremented on each ISSUE handshake. Also adds output full_stall_cnt_o (32), saturating, incremented each cycle in which any req_valid_i[k] && !req_ready_o[k]. Both counters reset to 0.
  - Undefined: these ports and counters do not exist.

Decomposition:
- segre_pkg gains:
  - ARB_NUM_CH = 2 and ARB_FIFO_DEPTH = 4; ARB_BUF_SIZE/ARB_PTR_SIZE are retired in favour of these.
  - typedef enum arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RSP}.
  - typedef struct packed arb_entry_t {wr, addr, line}.
- Sub-module segre_arb_fifo (one instance per channel, via generate) provides push/pop/full/empty for arb_entry_t.

Test Plan:
- Single read: ch0 pushes rd addr 0x0000_1000. mem_req_valid_o rises 2 cycles later with mem_rd_o=1, addr 0x1000. Memory returns line 0xDEAD...BEEF → rsp_valid_o=2'b01 for 1 cycle with that line.
- Round-robin: ch0 and ch1 each push 3 requests in the same cycles → grant order 0,1,0,1,0,1; rr_ptr alternates.
- Full FIFO: hold mem_req_ready_i=0 and push 6 requests on ch1 → ch1 accepts 4, then req_ready_o[1]=0 for the remaining 2. After drain, all accepted addresses reach memory in push order.
- Write ack: ch1 pushes wr addr 0x2000 line 0xA5 repeated → mem_wr_o=1, mem_line_o matches. On ack, rsp_valid_o=2'b10. A spurious mem_rsp_valid_i in IDLE produces no pulse.
- Backpressure: mem_req_ready_i held low 5 cycles → mem_addr_o, mem_line_o, mem_wr_o stable throughout, and no further pop occurs.
- Reset mid-WAIT_RSP: assert rsn_i low for 1 cycle, then send mem_rsp_valid_i → no rsp_valid_o, FSM IDLE, req_ready_o=all 1s. With SEGRE_ARB_STATS_EN defined, grant_cnt_o=0.
